// File: rtl/phase_sequencer_if.sv
// Handshake bundle between phase_sequencer and the game sub-blocks it drives.
// master = sequencer side, slave = stage/pad-ring side.
interface phase_sequencer_if #(
  parameter int NSTAGE = 3,
  parameter int FCNT_W = 8
);
  logic              run_i;
  logic              restart_i;
  logic [NSTAGE-1:0] stage_done_i;
  logic [NSTAGE-1:0] stage_en_o;
  logic [2:0]        cur_stage_o;
  logic              frame_tick_o;
  logic [FCNT_W-1:0] frame_cnt_o;
  logic              busy_o;
  logic              timeout_o;

  modport master (
    input  run_i, restart_i, stage_done_i,
    output stage_en_o, cur_stage_o, frame_tick_o, frame_cnt_o, busy_o, timeout_o
  );

  modport slave (
    output run_i, restart_i, stage_done_i,
    input  stage_en_o, cur_stage_o, frame_tick_o, frame_cnt_o, busy_o, timeout_o
  );
endinterface

// File: rtl/phase_sequencer.sv
// Round-robin stage sequencer with one-cycle idle gap, frame counter and pause at frame boundaries.
// Optional per-stage watchdog is built when PHASE_SEQUENCER_WATCHDOG_EN is defined.
module phase_sequencer #(
  parameter int NSTAGE  = 3,
  parameter int FCNT_W  = 8,
  parameter int TO_W    = 16,
  parameter int TIMEOUT = 1000
) (
  input logic               clk_i,
  input logic               rst_i,
  phase_sequencer_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

  localparam logic [2:0] LAST_STAGE = 3'(NSTAGE - 1);

  if (NSTAGE < 2 || NSTAGE > 8 || TIMEOUT < 1 || TIMEOUT > (2 ** TO_W) - 1) begin : g_bad_params
    $error("phase_sequencer: illegal NSTAGE/TIMEOUT/TO_W combination");
  end

  state_t            state_q, state_d;
  logic [2:0]        stage_q, stage_d;
  logic [FCNT_W-1:0] frame_cnt_q;
  logic              frame_tick_q;
  logic              busy_q;
  logic [NSTAGE-1:0] stage_mask;
  logic              done_active;
  logic              expire;
  logic              advance;

  assign stage_mask  = NSTAGE'(1) << stage_q;
  assign done_active = |(bus.stage_done_i & stage_mask);
  assign advance     = done_active | expire;

`ifdef PHASE_SEQUENCER_WATCHDOG_EN
  logic [TO_W-1:0] wd_q;
  logic            timeout_q;

  // A done on the expiry edge wins, so the flag only records genuine stalls.
  assign expire = (state_q == RUN) && (wd_q == TO_W'(TIMEOUT - 1)) && !done_active;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (bus.restart_i || state_q != RUN || advance) wd_q <= '0;
      else                                            wd_q <= wd_q + 1'b1;
      if (bus.restart_i)  timeout_q <= 1'b0;
      else if (expire)    timeout_q <= 1'b1;
    end
  end

  assign bus.timeout_o = timeout_q;
`else
  assign expire        = 1'b0;
  assign bus.timeout_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      stage_q      <= '0;
      frame_cnt_q  <= '0;
      frame_tick_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      stage_q      <= stage_d;
      busy_q       <= (state_d != IDLE);
      frame_tick_q <= (state_d == GAP) && (stage_d == LAST_STAGE);
      if (!bus.restart_i && state_q == GAP && stage_q == LAST_STAGE)
        frame_cnt_q <= frame_cnt_q + 1'b1;
    end
  end

  // Restart overrides everything; run_i only matters in IDLE and at the frame boundary.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    if (bus.restart_i) begin
      state_d = IDLE;
      stage_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.run_i) begin
            state_d = RUN;
            stage_d = '0;
          end
        end
        RUN: begin
          if (advance) state_d = GAP;
        end
        GAP: begin
          if (stage_q != LAST_STAGE) begin
            state_d = RUN;
            stage_d = stage_q + 3'd1;
          end else if (bus.run_i) begin
            state_d = RUN;
            stage_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          stage_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    bus.stage_en_o   = '0;
    if (state_q == RUN) bus.stage_en_o = stage_mask;
    bus.cur_stage_o  = stage_q;
    bus.frame_tick_o = frame_tick_q;
    bus.frame_cnt_o  = frame_cnt_q;
    bus.busy_o       = busy_q;
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer (NSTAGE=3, FCNT_W=2, TIMEOUT=10).
// Watchdog expectations follow PHASE_SEQUENCER_WATCHDOG_EN.
module tb_phase_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests   = 0;
  int   failed  = 0;
  int   exp_cnt = 0;

  always #5 clk = ~clk;

  phase_sequencer_if #(.NSTAGE(3), .FCNT_W(2)) bus ();

  phase_sequencer #(.NSTAGE(3), .FCNT_W(2), .TO_W(16), .TIMEOUT(10)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Pure driver: holds the active stage for len cycles, then one cycle into the GAP.
  task automatic step_stage(input int s, input int len);
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      if (c == len - 1) bus.stage_done_i = 3'(1 << s);
    end
    @(negedge clk);
    bus.stage_done_i = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.run_i = 1'b0;
    bus.restart_i = 1'b0;
    bus.stage_done_i = '0;
    repeat (2) @(negedge clk);
    tests++;
    if ({bus.stage_en_o, bus.cur_stage_o, bus.frame_tick_o, bus.frame_cnt_o, bus.busy_o, bus.timeout_o} !== 11'b0) begin
      failed++;
      $display("[TB] FAIL reset_outputs: got en=%b cur=%0d tick=%b cnt=%0d busy=%b to=%b, expected all zero",
               bus.stage_en_o, bus.cur_stage_o, bus.frame_tick_o, bus.frame_cnt_o, bus.busy_o, bus.timeout_o);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({bus.busy_o, bus.stage_en_o} !== 4'b0) begin
      failed++;
      $display("[TB] FAIL idle_no_run: got busy=%b en=%b expected 0/000", bus.busy_o, bus.stage_en_o);
    end
  endtask

  task automatic test_frames;
    bus.run_i = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int s = 0; s < 3; s++) begin
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          tests++;
          if ({bus.stage_en_o, bus.cur_stage_o, bus.busy_o} !== {3'(1 << s), 3'(s), 1'b1}) begin
            failed++;
            $display("[TB] FAIL run_stage f%0d s%0d c%0d: got en=%b cur=%0d busy=%b expected en=%b cur=%0d busy=1",
                     f, s, c, bus.stage_en_o, bus.cur_stage_o, bus.busy_o, 3'(1 << s), s);
          end
          if (s == 0 && c == 0) begin
            tests++;
            if (bus.frame_cnt_o !== 2'(exp_cnt)) begin
              failed++;
              $display("[TB] FAIL frame_cnt f%0d: got %0d expected %0d", f, bus.frame_cnt_o, exp_cnt);
            end
          end
          if (c == 2) bus.stage_done_i = 3'(1 << s);
        end
        @(negedge clk);
        bus.stage_done_i = '0;
        tests++;
        if ({bus.stage_en_o, bus.frame_tick_o, bus.cur_stage_o} !== {3'b000, (s == 2), 3'(s)}) begin
          failed++;
          $display("[TB] FAIL gap f%0d s%0d: got en=%b tick=%b cur=%0d expected en=000 tick=%b cur=%0d",
                   f, s, bus.stage_en_o, bus.frame_tick_o, bus.cur_stage_o, (s == 2), s);
        end
      end
      exp_cnt = (exp_cnt + 1) % 4;
    end
  endtask

  task automatic test_run_drop;
    step_stage(0, 3);
    tests++;
    if (bus.frame_cnt_o !== 2'(exp_cnt)) begin
      failed++;
      $display("[TB] FAIL drop_cnt_before: got %0d expected %0d", bus.frame_cnt_o, exp_cnt);
    end
    @(negedge clk);
    bus.run_i = 1'b0;
    tests++;
    if (bus.stage_en_o !== 3'b010) begin
      failed++;
      $display("[TB] FAIL drop_stage1: got en=%b expected 010", bus.stage_en_o);
    end
    @(negedge clk);
    bus.stage_done_i = 3'b010;
    @(negedge clk);
    bus.stage_done_i = '0;
    step_stage(2, 2);
    tests++;
    if ({bus.frame_tick_o, bus.busy_o} !== 2'b11) begin
      failed++;
      $display("[TB] FAIL drop_last_gap: got tick=%b busy=%b expected 1/1", bus.frame_tick_o, bus.busy_o);
    end
    exp_cnt = (exp_cnt + 1) % 4;
    @(negedge clk);
    tests++;
    if ({bus.stage_en_o, bus.busy_o, bus.frame_tick_o, bus.cur_stage_o, bus.frame_cnt_o} !==
        {3'b000, 1'b0, 1'b0, 3'd2, 2'(exp_cnt)}) begin
      failed++;
      $display("[TB] FAIL drop_idle: got en=%b busy=%b tick=%b cur=%0d cnt=%0d expected 000/0/0/2/%0d",
               bus.stage_en_o, bus.busy_o, bus.frame_tick_o, bus.cur_stage_o, bus.frame_cnt_o, exp_cnt);
    end
    repeat (3) @(negedge clk);
    tests++;
    if ({bus.stage_en_o, bus.busy_o} !== 4'b0) begin
      failed++;
      $display("[TB] FAIL drop_paused: got en=%b busy=%b expected 000/0", bus.stage_en_o, bus.busy_o);
    end
    bus.run_i = 1'b1;
    @(negedge clk);
    tests++;
    if ({bus.stage_en_o, bus.busy_o, bus.cur_stage_o} !== {3'b001, 1'b1, 3'd0}) begin
      failed++;
      $display("[TB] FAIL drop_resume: got en=%b busy=%b cur=%0d expected 001/1/0",
               bus.stage_en_o, bus.busy_o, bus.cur_stage_o);
    end
  endtask

  task automatic test_foreign_done;
    bus.stage_done_i = 3'b100;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if (bus.stage_en_o !== 3'b001) begin
        failed++;
        $display("[TB] FAIL foreign_ignored c%0d: got en=%b expected 001", i, bus.stage_en_o);
      end
    end
    bus.stage_done_i = 3'b101;
    @(negedge clk);
    bus.stage_done_i = 3'b100;
    tests++;
    if ({bus.stage_en_o, bus.cur_stage_o} !== {3'b000, 3'd0}) begin
      failed++;
      $display("[TB] FAIL foreign_gap: got en=%b cur=%0d expected 000/0", bus.stage_en_o, bus.cur_stage_o);
    end
    @(negedge clk);
    bus.stage_done_i = 3'b010;
    tests++;
    if (bus.stage_en_o !== 3'b010) begin
      failed++;
      $display("[TB] FAIL min_len_enter: got en=%b expected 010", bus.stage_en_o);
    end
    @(negedge clk);
    bus.stage_done_i = '0;
    tests++;
    if ({bus.stage_en_o, bus.cur_stage_o} !== {3'b000, 3'd1}) begin
      failed++;
      $display("[TB] FAIL min_len_gap: got en=%b cur=%0d expected 000/1", bus.stage_en_o, bus.cur_stage_o);
    end
    step_stage(2, 1);
    tests++;
    if (bus.frame_tick_o !== 1'b1) begin
      failed++;
      $display("[TB] FAIL foreign_tick: got %b expected 1", bus.frame_tick_o);
    end
    exp_cnt = (exp_cnt + 1) % 4;
  endtask

  task automatic test_wrap;
    for (int f = 0; f < 5; f++) begin
      step_stage(0, 1);
      tests++;
      if ({bus.frame_cnt_o, bus.frame_tick_o} !== {2'(exp_cnt), 1'b0}) begin
        failed++;
        $display("[TB] FAIL wrap_cnt f%0d: got cnt=%0d tick=%b expected cnt=%0d tick=0",
                 f, bus.frame_cnt_o, bus.frame_tick_o, exp_cnt);
      end
      step_stage(1, 1);
      step_stage(2, 1);
      tests++;
      if (bus.frame_tick_o !== 1'b1) begin
        failed++;
        $display("[TB] FAIL wrap_tick f%0d: got %b expected 1", f, bus.frame_tick_o);
      end
      exp_cnt = (exp_cnt + 1) % 4;
    end
  endtask

  task automatic test_restart;
    step_stage(0, 3);
    @(negedge clk);
    bus.restart_i = 1'b1;
    bus.stage_done_i = 3'b010;
    @(negedge clk);
    bus.restart_i = 1'b0;
    bus.stage_done_i = '0;
    tests++;
    if ({bus.stage_en_o, bus.cur_stage_o, bus.busy_o, bus.frame_tick_o, bus.timeout_o, bus.frame_cnt_o} !==
        {3'b000, 3'd0, 1'b0, 1'b0, 1'b0, 2'(exp_cnt)}) begin
      failed++;
      $display("[TB] FAIL restart_idle: got en=%b cur=%0d busy=%b tick=%b to=%b cnt=%0d expected 000/0/0/0/0/%0d",
               bus.stage_en_o, bus.cur_stage_o, bus.busy_o, bus.frame_tick_o, bus.timeout_o, bus.frame_cnt_o, exp_cnt);
    end
    @(negedge clk);
    tests++;
    if ({bus.stage_en_o, bus.busy_o} !== 4'b0011) begin
      failed++;
      $display("[TB] FAIL restart_resume: got en=%b busy=%b expected 001/1", bus.stage_en_o, bus.busy_o);
    end
  endtask

  task automatic test_watchdog;
    int n;
    bus.stage_done_i = 3'b001;
    @(negedge clk);
    bus.stage_done_i = '0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.stage_en_o == 3'b010) n++;
      else break;
    end
`ifdef PHASE_SEQUENCER_WATCHDOG_EN
    tests++;
    if ({8'(n), bus.stage_en_o, bus.timeout_o, bus.frame_tick_o} !== {8'd10, 3'b000, 1'b1, 1'b0}) begin
      failed++;
      $display("[TB] FAIL wd_expire: got len=%0d en=%b to=%b tick=%b expected 10/000/1/0",
               n, bus.stage_en_o, bus.timeout_o, bus.frame_tick_o);
    end
    @(negedge clk);
    bus.stage_done_i = 3'b100;
    tests++;
    if ({bus.stage_en_o, bus.timeout_o} !== 4'b1001) begin
      failed++;
      $display("[TB] FAIL wd_next_stage: got en=%b to=%b expected 100/1", bus.stage_en_o, bus.timeout_o);
    end
    @(negedge clk);
    bus.stage_done_i = '0;
    tests++;
    if ({bus.frame_tick_o, bus.timeout_o} !== 2'b11) begin
      failed++;
      $display("[TB] FAIL wd_sticky: got tick=%b to=%b expected 1/1", bus.frame_tick_o, bus.timeout_o);
    end
    @(negedge clk);
`else
    tests++;
    if ({8'(n), bus.stage_en_o, bus.timeout_o} !== {8'd40, 3'b010, 1'b0}) begin
      failed++;
      $display("[TB] FAIL wd_absent: got len=%0d en=%b to=%b expected 40/010/0", n, bus.stage_en_o, bus.timeout_o);
    end
`endif
    bus.restart_i = 1'b1;
    @(negedge clk);
    bus.restart_i = 1'b0;
    tests++;
    if ({bus.stage_en_o, bus.timeout_o, bus.cur_stage_o} !== 7'b0) begin
      failed++;
      $display("[TB] FAIL wd_restart: got en=%b to=%b cur=%0d expected 000/0/0",
               bus.stage_en_o, bus.timeout_o, bus.cur_stage_o);
    end
    @(negedge clk);
    repeat (8) @(negedge clk);
    tests++;
    if ({bus.stage_en_o, bus.timeout_o} !== 4'b0010) begin
      failed++;
      $display("[TB] FAIL wd_before_limit: got en=%b to=%b expected 001/0", bus.stage_en_o, bus.timeout_o);
    end
    @(negedge clk);
    bus.stage_done_i = 3'b001;
    tests++;
    if (bus.stage_en_o !== 3'b001) begin
      failed++;
      $display("[TB] FAIL wd_last_cycle: got en=%b expected 001", bus.stage_en_o);
    end
    @(negedge clk);
    bus.stage_done_i = '0;
    tests++;
    if ({bus.stage_en_o, bus.timeout_o} !== 4'b0000) begin
      failed++;
      $display("[TB] FAIL wd_done_on_expiry: got en=%b to=%b expected 000/0", bus.stage_en_o, bus.timeout_o);
    end
    @(negedge clk);
    tests++;
    if ({bus.stage_en_o, bus.timeout_o} !== 4'b0100) begin
      failed++;
      $display("[TB] FAIL wd_after_done: got en=%b to=%b expected 010/0", bus.stage_en_o, bus.timeout_o);
    end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_run_drop();
    test_foreign_done();
    test_wrap();
    test_restart();
    test_watchdog();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Parametrised successor to the fixed three-phase (input -> action -> display) game loop controller.
- Drives NSTAGE sub-blocks in strict round-robin order over a one-hot enable/done handshake, with a guaranteed idle gap between stages.
- Adds frame counting, a frame-boundary pause, synchronous restart, and an optional per-stage watchdog.
- Sits at the top level between the game sub-blocks (get_input, action, display, future stages) and the pad ring.

Parameters:
- NSTAGE, 3, number of sequenced stages (2..8); stage 0 runs first in each frame.
- FCNT_W, 8, width of the frame counter.
- TO_W, 16, watchdog counter width.
- TIMEOUT, 1000, watchdog limit in clk_i cycles per stage; 1 <= TIMEOUT <= 2^TO_W-1.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- run_i  in  1  run request; level-sensitive, sampled only in IDLE and at frame boundaries.
- restart_i  in  1  synchronous restart, active-high.
- stage_done_i  in  NSTAGE  per-stage done; only the bit of the active stage is observed.
- stage_en_o  out  NSTAGE  one-hot stage enable; all-zero when no stage is active.
- cur_stage_o  out  3  index of the current or last-active stage.
- frame_tick_o  out  1  one-cycle pulse when the last stage completes.
- frame_cnt_o  out  FCNT_W  completed-frame count; wraps from 2^FCNT_W-1 to 0.
- busy_o  out  1  high whenever state != IDLE.
- timeout_o  out  1  sticky watchdog flag; tied 0 when the watchdog is compiled out.

Behaviour:
- Reset (rst_i=1, asynchronous): state IDLE; stage_en_o=0, cur_stage_o=0, frame_tick_o=0, frame_cnt_o=0, busy_o=0, timeout_o=0, watchdog counter=0.
- States:
  - IDLE: all enables low. If run_i=1 at an edge, go to RUN with k=0; stage_en_o[0] rises on that edge.
  - RUN(k): stage_en_o = 1<<k and cur_stage_o=k. Stays in RUN while stage_done_i[k]=0. When stage_done_i[k]=1 at an edge, go to GAP; stage_en_o=0 from that edge. Done bits of non-active stages are ignored.
  - GAP: exactly one cycle with all enables low, so a sub-block never sees a continuous enable across stages.
    - If k<NSTAGE-1: next edge enters RUN(k+1).
    - If k=NSTAGE-1: frame_tick_o=1 during this GAP cycle, and frame_cnt_o increments (mod 2^FCNT_W) on the edge leaving GAP. That edge goes to RUN(0) if run_i=1, else to IDLE.
- Latency:
  - done[k] sampled to stage_en_o[k+1] high: 2 edges.
  - run_i high in IDLE to stage_en_o[0] high: 1 edge.
- run_i deasserted mid-frame has no effect; the frame always completes (pause occurs only at a frame boundary).
- stage_done_i[k] already high on the first cycle of RUN(k): accepted on that edge, giving a minimum stage length of 1 cycle.
- restart_i=1 at an edge: same result as reset except frame_cnt_o is retained. restart_i has priority over every other transition on that edge, including a simultaneous done or watchdog expiry. If run_i is high, operation resumes from IDLE on the following edge.
- cur_stage_o holds its last value in GAP and IDLE; it is 0 after reset or restart.
- busy_o is registered from state; frame_tick_o is registered and is never high for two consecutive cycles.

Optional Feature:
- Macro: PHASE_SEQUENCER_WATCHDOG_EN.
- Defined:
  - A TO_W-bit counter clears on entry to each RUN(k) and increments every RUN cycle.
  - If it reaches TIMEOUT-1 with stage_done_i[k] still 0, the sequencer advances exactly as if done had arrived (GAP, then next stage; frame_tick_o still fires for the last stage).
  - timeout_o sets and stays 1 until rst_i or restart_i.
  - A done arriving on the expiry edge counts as a normal done, and timeout_o is not set.
- Undefined: no counter is built, RUN(k) waits indefinitely, and timeout_o is constant 0.

Test Plan:
- rst_i pulse, then run_i=1 with each stage's done tied 2 cycles after its enable (NSTAGE=3) -> enables 001, 010, 100 in order, each followed by one all-zero GAP cycle; frame_tick_o pulses once per 12-cycle frame; frame_cnt_o=1, 2, 3...
- run_i dropped during stage 1 -> stages 1 and 2 still complete; frame_cnt_o increments; busy_o=0 after the GAP; stage_en_o stays 0 until run_i returns.
- stage_done_i[2] held high while stage 0 is active -> ignored; stage 0 stays enabled until stage_done_i[0] is asserted.
- FCNT_W=2, run 5 frames -> frame_cnt_o sequence 1, 2, 3, 0, 1.
- restart_i asserted together with stage_done_i[1] in RUN(1) -> next cycle is IDLE with stage_en_o=0 and cur_stage_o=0, frame_cnt_o unchanged; stage_en_o[0] rises on the following edge when run_i=1.
- With PHASE_SEQUENCER_WATCHDOG_EN and TIMEOUT=10, stage 1 never signals done -> stage_en_o[1] is high for exactly 10 cycles, then GAP, then stage 2; timeout_o=1 and sticky. Without the macro, stage_en_o[1] stays high and timeout_o=0.
